// File: rtl/hwpe_stream_package.sv
// -----------------------------------------------------------------------------
// hwpe_stream_package
// Shared types for the HWPE stream/TCDM blocks.
//   state_sourcesink_t : two-state FSM encoding used by stream sources/sinks
//   ctrl_reader_t      : job descriptor for hwpe_stream_tcdm_reader
//                        (req_start, base_addr, word_stride in bytes, word_count)
//   flags_reader_t     : status of hwpe_stream_tcdm_reader (ready_start, busy, done)
// -----------------------------------------------------------------------------
package hwpe_stream_package;

    localparam int unsigned READER_CNT_WIDTH = 16;

    typedef enum logic {
        STREAM_IDLE,
        STREAM_WORKING
    } state_sourcesink_t;

    typedef struct packed {
        logic                        req_start;
        logic [31:0]                 base_addr;
        logic [31:0]                 word_stride;
        logic [READER_CNT_WIDTH-1:0] word_count;
    } ctrl_reader_t;

    typedef struct packed {
        logic ready_start;
        logic busy;
        logic done;
    } flags_reader_t;

endpackage

// File: rtl/hwpe_stream_fifo.sv
// -----------------------------------------------------------------------------
// hwpe_stream_fifo
// Registered (non fall-through) FIFO: a word pushed in cycle N is visible at
// the head in cycle N+1. FIFO_DEPTH must be a power of two, >= 2.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   clear_i            synchronous flush (wins over a same-cycle push/pop)
//   test_mode_i        DFT mode (no effect on this register-based storage)
//   push_valid_i/data  write side; a push while full is discarded
//   pop_ready_i        consume the head word
//   pop_valid_o/data   head word and its validity (FIFO not empty)
//   full_o             FIFO holds FIFO_DEPTH words
// -----------------------------------------------------------------------------
module hwpe_stream_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  test_mode_i,
    input  logic                  push_valid_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_ready_i,
    output logic                  pop_valid_o,
    output logic [DATA_WIDTH-1:0] pop_data_o,
    output logic                  full_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW:0]           cnt_q, cnt_d;
    logic                  push, pop;
    logic                  unused_test_mode;

    assign unused_test_mode = test_mode_i;

    assign pop_valid_o = (cnt_q != '0);
    assign full_o      = (cnt_q == (AW+1)'(FIFO_DEPTH));
    assign pop_data_o  = mem_q[rd_ptr_q];

    assign push = push_valid_i & ~full_o;
    assign pop  = pop_ready_i & pop_valid_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        // power-of-two depth: pointers wrap naturally
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // storage carries data only, so it is left out of reset
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/hwpe_stream_tcdm_reader.sv
// -----------------------------------------------------------------------------
// hwpe_stream_tcdm_reader
// Issues a strided sequence of TCDM word reads and forwards the responses as
// an HWPE stream through a response FIFO. Requests are credit-limited so a
// response always finds a free FIFO slot.
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   test_mode_i           DFT mode, forwarded to the FIFO
//   clear_i               synchronous soft clear (same state as reset)
//   tcdm_*                TCDM master (req/gnt/add/wen/be/data, r_data/r_valid)
//   stream_*              HWPE stream source (valid/ready/data/strb)
//   ctrl_i                job descriptor (start, base, stride, count)
//   flags_o               ready_start / busy / done (1-cycle pulse)
// -----------------------------------------------------------------------------
module hwpe_stream_tcdm_reader
    import hwpe_stream_package::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_WIDTH  = READER_CNT_WIDTH
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    test_mode_i,
    input  logic                    clear_i,
    output logic                    tcdm_req_o,
    input  logic                    tcdm_gnt_i,
    output logic [31:0]             tcdm_add_o,
    output logic                    tcdm_wen_o,
    output logic [3:0]              tcdm_be_o,
    output logic [31:0]             tcdm_data_o,
    input  logic [31:0]             tcdm_r_data_i,
    input  logic                    tcdm_r_valid_i,
    output logic                    stream_valid_o,
    input  logic                    stream_ready_i,
    output logic [DATA_WIDTH-1:0]   stream_data_o,
    output logic [DATA_WIDTH/8-1:0] stream_strb_o,
    input  ctrl_reader_t            ctrl_i,
    output flags_reader_t           flags_o
);

    localparam int unsigned CRW = $clog2(FIFO_DEPTH) + 1;

    state_sourcesink_t    state_q, state_d;
    logic [31:0]          addr_q, addr_d;
    logic [31:0]          stride_q, stride_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [CNT_WIDTH-1:0] issued_q, issued_d;
    logic [CNT_WIDTH-1:0] delivered_q, delivered_d;
    logic [CRW-1:0]       credits_q, credits_d;
    logic                 done_q, done_d;
    logic                 clear_q;
    logic                 grant, handshake, fifo_push;
    logic                 unused_fifo_full;

    assign tcdm_req_o = (state_q == STREAM_WORKING) && (issued_q < count_q)
                        && (credits_q != '0);
    assign tcdm_add_o  = addr_q;
    assign tcdm_wen_o  = 1'b1;
    assign tcdm_be_o   = 4'hF;
    assign tcdm_data_o = '0;

    assign grant     = tcdm_req_o & tcdm_gnt_i;
    assign handshake = stream_valid_o & stream_ready_i;

    // A response in the cycle right after a clear belongs to a pre-clear
    // grant whose credit was already restored by the clear: drop it.
    assign fifo_push = tcdm_r_valid_i & ~clear_q;

    assign stream_strb_o       = '1;
    assign flags_o.ready_start = (state_q == STREAM_IDLE);
    assign flags_o.busy        = (state_q == STREAM_WORKING);
    assign flags_o.done        = done_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        stride_d    = stride_q;
        count_d     = count_q;
        issued_d    = issued_q;
        delivered_d = delivered_q;
        credits_d   = credits_q;
        done_d      = 1'b0;

        case (state_q)
            STREAM_IDLE: begin
                if (ctrl_i.req_start) begin
                    if (ctrl_i.word_count != '0) begin
                        addr_d      = ctrl_i.base_addr;
                        stride_d    = ctrl_i.word_stride;
                        count_d     = CNT_WIDTH'(ctrl_i.word_count);
                        issued_d    = '0;
                        delivered_d = '0;
                        credits_d   = CRW'(FIFO_DEPTH);
                        state_d     = STREAM_WORKING;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            STREAM_WORKING: begin
                if (grant) begin
                    addr_d   = addr_q + stride_q;
                    issued_d = issued_q + CNT_WIDTH'(1);
                end
                // a grant and a handshake in the same cycle cancel out
                case ({grant, handshake})
                    2'b10:   credits_d = credits_q - CRW'(1);
                    2'b01:   credits_d = credits_q + CRW'(1);
                    default: credits_d = credits_q;
                endcase
                if (handshake) begin
                    delivered_d = delivered_q + CNT_WIDTH'(1);
                    if (delivered_d == count_q) begin
                        state_d = STREAM_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = STREAM_IDLE;
        endcase

        if (clear_i) begin
            state_d     = STREAM_IDLE;
            addr_d      = '0;
            stride_d    = '0;
            count_d     = '0;
            issued_d    = '0;
            delivered_d = '0;
            credits_d   = CRW'(FIFO_DEPTH);
            done_d      = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= STREAM_IDLE;
            addr_q      <= '0;
            stride_q    <= '0;
            count_q     <= '0;
            issued_q    <= '0;
            delivered_q <= '0;
            credits_q   <= CRW'(FIFO_DEPTH);
            done_q      <= 1'b0;
            clear_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            stride_q    <= stride_d;
            count_q     <= count_d;
            issued_q    <= issued_d;
            delivered_q <= delivered_d;
            credits_q   <= credits_d;
            done_q      <= done_d;
            clear_q     <= clear_i;
        end
    end

    hwpe_stream_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) i_resp_fifo (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (clear_i),
        .test_mode_i  (test_mode_i),
        .push_valid_i (fifo_push),
        .push_data_i  (tcdm_r_data_i),
        .pop_ready_i  (stream_ready_i),
        .pop_valid_o  (stream_valid_o),
        .pop_data_o   (stream_data_o),
        .full_o       (unused_fifo_full)
    );

endmodule

// File: tb/tb_hwpe_stream_tcdm_reader.sv
// -----------------------------------------------------------------------------
// tb_hwpe_stream_tcdm_reader
// Self-checking bench: a TCDM memory model answers every grant one cycle later
// with data derived from the address; a job-level reference model tracks
// words requested, received and delivered and predicts req/valid/busy/done.
// -----------------------------------------------------------------------------
module tb_hwpe_stream_tcdm_reader;
    import hwpe_stream_package::*;

    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          test_mode = 1'b0;
    logic          clear = 1'b0;
    logic          tcdm_req;
    logic          tcdm_gnt = 1'b0;
    logic [31:0]   tcdm_add;
    logic          tcdm_wen;
    logic [3:0]    tcdm_be;
    logic [31:0]   tcdm_data;
    logic [31:0]   tcdm_r_data = '0;
    logic          tcdm_r_valid = 1'b0;
    logic          stream_valid;
    logic          stream_ready = 1'b0;
    logic [31:0]   stream_data;
    logic [3:0]    stream_strb;
    ctrl_reader_t  ctrl = '0;
    flags_reader_t flags;

    always #5 clk = ~clk;

    hwpe_stream_tcdm_reader #(
        .DATA_WIDTH (32),
        .FIFO_DEPTH (DEPTH),
        .CNT_WIDTH  (16)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .test_mode_i    (test_mode),
        .clear_i        (clear),
        .tcdm_req_o     (tcdm_req),
        .tcdm_gnt_i     (tcdm_gnt),
        .tcdm_add_o     (tcdm_add),
        .tcdm_wen_o     (tcdm_wen),
        .tcdm_be_o      (tcdm_be),
        .tcdm_data_o    (tcdm_data),
        .tcdm_r_data_i  (tcdm_r_data),
        .tcdm_r_valid_i (tcdm_r_valid),
        .stream_valid_o (stream_valid),
        .stream_ready_i (stream_ready),
        .stream_data_o  (stream_data),
        .stream_strb_o  (stream_strb),
        .ctrl_i         (ctrl),
        .flags_o        (flags)
    );

    int total = 0;
    int bad   = 0;

    // stimulus knobs
    int gnt_pct = 100;
    int rdy_pct = 100;
    int clear_at_grant = -1;

    // memory model pipeline
    logic        rv_next = 1'b0;
    logic [31:0] rd_next = '0;
    logic        clear_prev = 1'b0;

    // reference model
    logic        m_active = 1'b0;
    logic        m_done = 1'b0;
    logic [31:0] m_base = '0;
    logic [31:0] m_stride = '0;
    int          m_count = 0;
    int          m_granted = 0;
    int          m_received = 0;
    int          m_delivered = 0;

    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int last_rv_cyc = -1;
    int first_valid_cyc = -1;
    int req_seen = 0;
    int s_cyc = 0;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_3C3C;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle, entered and left at a negedge.
    task automatic cycle();
        logic g, r, grant, hs, clr, nxt_active, nxt_done;
        logic [31:0] k_addr;

        check("busy", 32'(flags.busy), 32'(m_active));
        check("ready_start", 32'(flags.ready_start), 32'(!m_active));
        check("done", 32'(flags.done), 32'(m_done));
        check("req", 32'(tcdm_req),
              32'(m_active && (m_granted < m_count) && ((m_granted - m_delivered) < DEPTH)));
        check("valid", 32'(stream_valid), 32'(m_received > m_delivered));
        if (flags.done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (stream_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (tcdm_req) req_seen++;

        g = (int'($urandom_range(99)) < gnt_pct);
        r = (int'($urandom_range(99)) < rdy_pct);
        tcdm_gnt     = g;
        stream_ready = r;
        tcdm_r_valid = rv_next;
        tcdm_r_data  = rd_next;
        grant = tcdm_req & g;
        hs    = stream_valid & r;
        clr   = (clear_at_grant >= 0) && grant && (m_granted == clear_at_grant);
        clear = clr;

        if (grant) begin
            k_addr = m_base + 32'(m_granted) * m_stride;
            check("addr", tcdm_add, k_addr);
            check("wen", 32'(tcdm_wen), 32'd1);
            check("be", 32'(tcdm_be), 32'hF);
            check("wdata", tcdm_data, 32'd0);
            rd_next = memfn(tcdm_add);
            m_granted++;
        end
        rv_next = grant;

        if (tcdm_r_valid) last_rv_cyc = cyc;
        if (tcdm_r_valid && !clear_prev) begin
            m_received++;
            check("fifo_no_overflow", 32'((m_received - m_delivered) <= DEPTH), 32'd1);
        end
        if (hs) begin
            check("data", stream_data, memfn(m_base + 32'(m_delivered) * m_stride));
            check("strb", 32'(stream_strb), 32'hF);
            m_delivered++;
        end

        nxt_active = m_active;
        nxt_done   = 1'b0;
        if (clr) begin
            nxt_active     = 1'b0;
            m_granted      = 0;
            m_received     = 0;
            m_delivered    = 0;
            clear_at_grant = -1;
        end else if (!m_active && ctrl.req_start) begin
            if (ctrl.word_count != '0) begin
                nxt_active  = 1'b1;
                m_base      = ctrl.base_addr;
                m_stride    = ctrl.word_stride;
                m_count     = int'(ctrl.word_count);
                m_granted   = 0;
                m_received  = 0;
                m_delivered = 0;
            end else begin
                nxt_done = 1'b1;
            end
        end else if (m_active && hs && (m_delivered == m_count)) begin
            nxt_active = 1'b0;
            nxt_done   = 1'b1;
        end
        clear_prev = clr;

        @(posedge clk);
        @(negedge clk);
        clear    = 1'b0;
        cyc++;
        m_active = nxt_active;
        m_done   = nxt_done;
    endtask

    task automatic start(input logic [31:0] b, input logic [31:0] s, input int n);
        done_cnt        = 0;
        first_valid_cyc = -1;
        req_seen        = 0;
        s_cyc           = cyc;
        ctrl.req_start   = 1'b1;
        ctrl.base_addr   = b;
        ctrl.word_stride = s;
        ctrl.word_count  = 16'(n);
        cycle();
        ctrl.req_start = 1'b0;
    endtask

    task automatic run_idle(input int bound);
        for (int i = 0; i < bound && m_active; i++) cycle();
        check("job_finished_in_time", 32'(m_active), 32'd0);
        cycle();
        cycle();
    endtask

    initial begin
        #23 rst_n = 1'b1;
        @(negedge clk);

        // reset state
        check("rst_req", 32'(tcdm_req), 32'd0);
        check("rst_add", tcdm_add, 32'd0);
        check("rst_wen", 32'(tcdm_wen), 32'd1);
        check("rst_be", 32'(tcdm_be), 32'hF);
        check("rst_wdata", tcdm_data, 32'd0);
        check("rst_valid", 32'(stream_valid), 32'd0);
        check("rst_ready_start", 32'(flags.ready_start), 32'd1);
        check("rst_busy", 32'(flags.busy), 32'd0);
        check("rst_done", 32'(flags.done), 32'd0);

        // basic: full throughput
        gnt_pct = 100; rdy_pct = 100;
        start(32'h0000_1000, 32'd4, 8);
        run_idle(100);
        check("basic_first_valid_latency", 32'(first_valid_cyc - s_cyc), 32'd3);
        check("basic_done_after_last_rvalid", 32'(done_cyc - last_rv_cyc), 32'd2);
        check("basic_done_total_latency", 32'(done_cyc - s_cyc), 32'd11);
        check("basic_done_once", 32'(done_cnt), 32'd1);
        check("basic_delivered", 32'(m_delivered), 32'd8);

        // address wrap-around
        start(32'hFFFF_FFF8, 32'd8, 3);
        run_idle(50);
        check("wrap_delivered", 32'(m_delivered), 32'd3);
        check("wrap_done_once", 32'(done_cnt), 32'd1);

        // backpressure: ready low for 20 cycles
        rdy_pct = 0;
        start(32'h0000_3000, 32'd4, 10);
        repeat (20) cycle();
        check("bp_grants_before_stall", 32'(m_granted), 32'd4);
        check("bp_nothing_delivered", 32'(m_delivered), 32'd0);
        rdy_pct = 100;
        run_idle(200);
        check("bp_delivered", 32'(m_delivered), 32'd10);
        check("bp_done_once", 32'(done_cnt), 32'd1);

        // contention: random grant and ready
        gnt_pct = 30; rdy_pct = 50;
        start(32'h0000_4000, 32'd12, 64);
        run_idle(3000);
        check("cont_delivered", 32'(m_delivered), 32'd64);
        check("cont_done_once", 32'(done_cnt), 32'd1);

        // zero word count
        gnt_pct = 100; rdy_pct = 100;
        start(32'h0000_5000, 32'd4, 0);
        cycle();
        cycle();
        check("zero_done_once", 32'(done_cnt), 32'd1);
        check("zero_done_next_cycle", 32'(done_cyc - s_cyc), 32'd1);
        check("zero_no_req", 32'(req_seen), 32'd0);

        // clear during the third grant
        rdy_pct = 0;
        clear_at_grant = 2;
        start(32'h0000_6000, 32'd4, 16);
        for (int i = 0; i < 20 && clear_at_grant >= 0; i++) cycle();
        check("clr_triggered", 32'(clear_at_grant), 32'hFFFF_FFFF);
        repeat (4) cycle();
        check("clr_no_done", 32'(done_cnt), 32'd0);
        check("clr_fifo_empty", 32'(stream_valid), 32'd0);

        // restart after clear: credits back to full depth
        start(32'h0000_2000, 32'd4, 6);
        repeat (10) cycle();
        check("clr_restart_grants", 32'(m_granted), 32'd4);
        rdy_pct = 100;
        run_idle(100);
        check("clr_restart_delivered", 32'(m_delivered), 32'd6);
        check("clr_restart_done_once", 32'(done_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
